// File: rtl/trail_board_reader.sv
`timescale 1ns/1ps
// Shadow copy of the playfield fed by the pixel-write bus; answers pipelined cell queries for collision checks.
// Optional sticky crash capture: define TRAIL_CRASH_STICKY_EN.
module trail_board_reader #(
  parameter int WIDTH       = 100,
  parameter int HEIGHT      = 100,
  parameter int X_BITS      = 7,
  parameter int Y_BITS      = 7,
  parameter int COLOUR_BITS = 3
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   clear_req,
  output logic                   clear_busy,
  input  logic                   plot,
  input  logic [X_BITS-1:0]      x,
  input  logic [Y_BITS-1:0]      y,
  input  logic [COLOUR_BITS-1:0] colour,
  input  logic                   q_valid,
  output logic                   q_ready,
  input  logic [X_BITS-1:0]      q_x,
  input  logic [Y_BITS-1:0]      q_y,
  output logic                   r_valid,
  output logic                   r_occupied,
  output logic [COLOUR_BITS-1:0] r_colour,
`ifdef TRAIL_CRASH_STICKY_EN
  output logic                   crash_flag,
  output logic [COLOUR_BITS-1:0] crash_colour,
`endif
  output logic                   r_oob
);

  localparam int CELLS  = WIDTH * HEIGHT;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int FULL_W = X_BITS + Y_BITS + 1;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(CELLS - 1);
  localparam logic [X_BITS:0]   W_LIM = (X_BITS+1)'(WIDTH);
  localparam logic [Y_BITS:0]   H_LIM = (Y_BITS+1)'(HEIGHT);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] sweep, sweep_nxt;

  // Product is formed wide enough for any coordinate, then narrowed once the cell is known in range.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [X_BITS-1:0] cx,
                                                  input logic [Y_BITS-1:0] cy);
    return ADDR_W'(FULL_W'(cy) * FULL_W'(WIDTH) + FULL_W'(cx));
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= CLEAR;
      sweep <= '0;
    end else begin
      state <= state_nxt;
      sweep <= sweep_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep;
    case (state)
      CLEAR:
        if (clear_req)          sweep_nxt = '0;
        else if (sweep == LAST) state_nxt = RUN;
        else                    sweep_nxt = sweep + ADDR_W'(1);
      RUN:
        if (clear_req) begin
          state_nxt = CLEAR;
          sweep_nxt = '0;
        end
    endcase
  end

  assign clear_busy = (state == CLEAR);
  assign q_ready    = (state == RUN);

  // Single write port: the clear sweep owns it in CLEAR, the plot bus in RUN.
  logic                   plot_ok;
  logic [ADDR_W-1:0]      plot_addr, wr_addr;
  logic                   wr_en;
  logic [COLOUR_BITS-1:0] wr_data;
  logic [COLOUR_BITS-1:0] mem [CELLS];

  assign plot_ok   = plot && q_ready && ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);
  assign plot_addr = cell_addr(x, y);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = sweep;
    wr_data = '0;
    if (clear_busy) begin
      wr_en = 1'b1;
    end else if (plot_ok) begin
      wr_en   = 1'b1;
      wr_addr = plot_addr;
      wr_data = colour;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Query path: stage 1 is the RAM read plus bypass capture, stage 2 the result registers.
  logic                   q_acc, q_oob;
  logic [ADDR_W-1:0]      rd_addr;
  logic [COLOUR_BITS-1:0] rd_data, byp_data, s1_col;
  logic                   byp_hit, s1_oob;
  logic [1:0]             vld_pipe;

  assign q_acc   = q_valid && q_ready;
  assign q_oob   = !(({1'b0, q_x} < W_LIM) && ({1'b0, q_y} < H_LIM));
  assign rd_addr = q_oob ? '0 : cell_addr(q_x, q_y);

  always_ff @(posedge clock) begin
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      s1_oob   <= 1'b0;
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], q_acc};
      s1_oob   <= q_oob;
      byp_hit  <= plot_ok && (plot_addr == rd_addr);
      byp_data <= colour;
    end
  end

  // RAM reads old data on a same-cycle collision; the bypass gives write-first behaviour.
  assign s1_col  = byp_hit ? byp_data : rd_data;
  assign r_valid = vld_pipe[1];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_occupied <= 1'b0;
      r_colour   <= '0;
      r_oob      <= 1'b0;
    end else if (vld_pipe[0]) begin
      r_oob      <= s1_oob;
      r_colour   <= s1_oob ? '0 : s1_col;
      r_occupied <= s1_oob || (s1_col != '0);
    end
  end

`ifdef TRAIL_CRASH_STICKY_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      crash_flag   <= 1'b0;
      crash_colour <= '0;
    end else if (clear_req) begin
      crash_flag   <= 1'b0;
      crash_colour <= '0;
    end else if (r_valid && r_occupied && !crash_flag) begin
      crash_flag   <= 1'b1;
      crash_colour <= r_colour;
    end
  end
`endif

endmodule
